down_counter_chain: RTL and testbench

- Synchronous down-counter of WIDTH bits built as a ripple-borrow chain of 4-bit slices.
- This is the decrementing counterpart of the team's up-counting 4-bit-slice counter chain.
- Used for dividers, timeouts and one-shot delays, where a preset value is counted down to zero.
- Load, reset and the borrow chain use the same slice-cascade model as the up-counter, so it maps cleanly onto 4-bit counter parts.

---
 rtl/down_counter_chain_pkg.sv | 13 +
 rtl/down_counter_chain_if.sv | 13 +
 rtl/down_counter_chain_slice.sv | 23 ++
 rtl/down_counter_chain.sv | 58 +++++
 tb/tb_down_counter_chain.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/down_counter_chain_pkg.sv
// Shared definitions for the 4-bit-slice counter chains: slice width and
// the elaboration-time width legality check.
package counter_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef logic [SLICE_W-1:0] nibble_t;

  function automatic bit width_ok(int unsigned w);
    return (w >= SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/down_counter_chain_if.sv
// Count-enable / preset / status bundle of the down-counter chain.
interface down_counter_chain_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ce;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             underflow;

  modport master (output ce, preset, input counter, tc, underflow);
  modport slave  (input ce, preset, output counter, tc, underflow);
endinterface

// File: rtl/down_counter_chain_slice.sv
// One 4-bit down-counting slice: synchronous load beats decrement; the
// borrow-out enables the next slice only when this slice is at zero.
module down_slice4
  import counter_pkg::*;
(
  input  logic    clk,
  input  logic    ld,
  input  nibble_t d,
  input  logic    bi,
  output nibble_t q,
  output logic    bo
);

  localparam nibble_t ONE = nibble_t'(1);

  always_ff @(posedge clk) begin
    if (ld)      q <= d;
    else if (bi) q <= q - ONE;
  end

  assign bo = bi & (q == '0);

endmodule

// File: rtl/down_counter_chain.sv
// WIDTH-bit synchronous down-counter built from a ripple-borrow chain of
// 4-bit slices, with periodic auto-reload or one-shot stop at zero.
module down_counter_chain
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          AUTORELOAD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_chain_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("down_counter_chain: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [WIDTH-1:0] counter;
  logic [NSLICE:0]  borrow;
  logic             zero;
  logic             tc;
  logic             ld;
  logic             underflow;

  assign zero = (counter == '0);

  // With the chain ungated, the borrow out of the top slice is exactly ce & zero.
  assign tc = AUTORELOAD ? borrow[NSLICE] : (bus.ce & zero);

  assign ld = ~rst | (AUTORELOAD & tc);

  // One-shot mode blocks the chain at zero so it never wraps to all-ones.
  assign borrow[0] = AUTORELOAD ? bus.ce : (bus.ce & ~zero);

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    down_slice4 u_slice (
      .clk (clk),
      .ld  (ld),
      .d   (bus.preset[k*SLICE_W +: SLICE_W]),
      .bi  (borrow[k]),
      .q   (counter[k*SLICE_W +: SLICE_W]),
      .bo  (borrow[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst)            underflow <= 1'b0;
    else if (AUTORELOAD) underflow <= tc;
    else                 underflow <= bus.ce & (counter == WIDTH'(1));
  end

  assign bus.counter   = counter;
  assign bus.tc        = tc;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_down_counter_chain.sv
// Bench for down_counter_chain: three configurations (8-bit periodic,
// 8-bit one-shot, 16-bit periodic), vector table, hand sequence, random run.
module tb_down_counter_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  down_counter_chain_if #(.WIDTH(8))  bus_a ();
  down_counter_chain_if #(.WIDTH(8))  bus_b ();
  down_counter_chain_if #(.WIDTH(16)) bus_c ();

  down_counter_chain #(.WIDTH(8),  .AUTORELOAD(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  down_counter_chain #(.WIDTH(8),  .AUTORELOAD(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  down_counter_chain #(.WIDTH(16), .AUTORELOAD(1'b1)) dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned inst;
    logic        rst;
    logic        ce;
    logic [15:0] preset;
    logic        chk_tc;
    logic        exp_tc;
    logic [15:0] exp_cnt;
    logic        exp_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int unsigned inst, logic r, logic c, logic [15:0] p,
                              logic chk, logic t, logic [15:0] cnt, logic uf);
    vec_t v;
    v.inst = inst; v.rst = r; v.ce = c; v.preset = p;
    v.chk_tc = chk; v.exp_tc = t; v.exp_cnt = cnt; v.exp_uf = uf;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(int unsigned i, logic r, logic c, logic [15:0] p);
    case (i)
      0: begin rst_a = r; bus_a.ce = c; bus_a.preset = p[7:0]; end
      1: begin rst_b = r; bus_b.ce = c; bus_b.preset = p[7:0]; end
      default: begin rst_c = r; bus_c.ce = c; bus_c.preset = p; end
    endcase
  endtask

  task automatic idle_all();
    rst_a = 1'b1; bus_a.ce = 1'b0;
    rst_b = 1'b1; bus_b.ce = 1'b0;
    rst_c = 1'b1; bus_c.ce = 1'b0;
  endtask

  function automatic logic [15:0] rd_cnt(int unsigned i);
    case (i)
      0: return {8'h00, bus_a.counter};
      1: return {8'h00, bus_b.counter};
      default: return bus_c.counter;
    endcase
  endfunction

  function automatic logic rd_tc(int unsigned i);
    case (i)
      0: return bus_a.tc;
      1: return bus_b.tc;
      default: return bus_c.tc;
    endcase
  endfunction

  function automatic logic rd_uf(int unsigned i);
    case (i)
      0: return bus_a.underflow;
      1: return bus_b.underflow;
      default: return bus_c.underflow;
    endcase
  endfunction

  function automatic logic rd_b4(int unsigned i);
    case (i)
      0: return dut_a.borrow[1];
      1: return dut_b.borrow[1];
      default: return dut_c.borrow[1];
    endcase
  endfunction

  // Reference model: counter as a plain number following the counting rules.
  logic [15:0] m_cnt [3];
  logic [15:0] m_mask [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
  bit          m_ar   [3] = '{1'b1, 1'b0, 1'b1};

  task automatic model_step(int unsigned i, logic r, logic c, logic [15:0] p,
                            output logic uf);
    if (!r) begin
      m_cnt[i] = p & m_mask[i];
      uf = 1'b0;
    end else if (!c) begin
      uf = 1'b0;
    end else if (m_cnt[i] == 0) begin
      if (m_ar[i]) begin
        m_cnt[i] = p & m_mask[i];
        uf = 1'b1;
      end else begin
        uf = 1'b0;
      end
    end else begin
      m_cnt[i] = m_cnt[i] - 16'd1;
      uf = !m_ar[i] && (m_cnt[i] == 0);
    end
  endtask

  initial begin
    logic r [3];
    logic c [3];
    logic [15:0] p [3];
    logic uf;

    idle_all();
    bus_a.preset = '0; bus_b.preset = '0; bus_c.preset = '0;

    // inst, rst, ce, preset, chk_tc, tc, counter-after, underflow-after
    vecs.push_back(mk(0, 0, 1, 16'h03, 0, 0, 16'h03, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 0, 16'h02, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 0, 16'h01, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 0, 16'h00, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 1, 16'h03, 1));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 0, 16'h02, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 0, 16'h01, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 0, 16'h00, 0));
    vecs.push_back(mk(0, 1, 1, 16'h03, 1, 1, 16'h03, 1));
    vecs.push_back(mk(0, 0, 1, 16'h05, 1, 0, 16'h05, 0));
    vecs.push_back(mk(0, 1, 1, 16'h05, 1, 0, 16'h04, 0));
    vecs.push_back(mk(0, 1, 0, 16'h05, 1, 0, 16'h04, 0));
    vecs.push_back(mk(0, 1, 1, 16'h05, 1, 0, 16'h03, 0));
    vecs.push_back(mk(0, 1, 0, 16'h05, 1, 0, 16'h03, 0));
    vecs.push_back(mk(0, 0, 0, 16'h7B, 1, 0, 16'h7B, 0));
    vecs.push_back(mk(0, 1, 1, 16'h7B, 1, 0, 16'h7A, 0));
    vecs.push_back(mk(0, 0, 1, 16'h21, 1, 0, 16'h21, 0));
    vecs.push_back(mk(1, 0, 1, 16'h02, 0, 0, 16'h02, 0));
    vecs.push_back(mk(1, 1, 1, 16'h02, 1, 0, 16'h01, 0));
    vecs.push_back(mk(1, 1, 1, 16'h02, 1, 0, 16'h00, 1));
    vecs.push_back(mk(1, 1, 1, 16'h02, 1, 1, 16'h00, 0));
    vecs.push_back(mk(1, 1, 1, 16'h02, 1, 1, 16'h00, 0));
    vecs.push_back(mk(1, 1, 1, 16'h02, 1, 1, 16'h00, 0));
    vecs.push_back(mk(1, 1, 0, 16'h02, 1, 0, 16'h00, 0));
    vecs.push_back(mk(1, 0, 1, 16'h00, 1, 1, 16'h00, 0));
    vecs.push_back(mk(1, 1, 1, 16'h00, 1, 1, 16'h00, 0));
    vecs.push_back(mk(1, 0, 0, 16'h01, 1, 0, 16'h01, 0));
    vecs.push_back(mk(1, 1, 1, 16'h01, 1, 0, 16'h00, 1));
    vecs.push_back(mk(2, 0, 1, 16'h0000, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(2, 1, 1, 16'h0000, 1, 1, 16'h0000, 1));
    vecs.push_back(mk(2, 1, 1, 16'h0000, 1, 1, 16'h0000, 1));
    vecs.push_back(mk(2, 1, 0, 16'h0000, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(2, 0, 1, 16'h0000, 1, 1, 16'h0000, 0));
    vecs.push_back(mk(2, 0, 0, 16'hFFFF, 1, 0, 16'hFFFF, 0));
    vecs.push_back(mk(2, 1, 1, 16'hFFFF, 1, 0, 16'hFFFE, 0));
    vecs.push_back(mk(2, 0, 0, 16'h1000, 1, 0, 16'h1000, 0));
    vecs.push_back(mk(2, 1, 1, 16'h1000, 1, 0, 16'h0FFF, 0));

    foreach (vecs[n]) begin
      @(negedge clk);
      idle_all();
      drive(vecs[n].inst, vecs[n].rst, vecs[n].ce, vecs[n].preset);
      #1;
      if (vecs[n].chk_tc)
        check($sformatf("row%0d_tc", n), 32'(rd_tc(vecs[n].inst)), 32'(vecs[n].exp_tc));
      @(posedge clk); #1;
      check($sformatf("row%0d_counter", n), 32'(rd_cnt(vecs[n].inst)), 32'(vecs[n].exp_cnt));
      check($sformatf("row%0d_underflow", n), 32'(rd_uf(vecs[n].inst)), 32'(vecs[n].exp_uf));
    end

    // Nibble borrow: b[4] only with ce=1 and low nibble zero.
    @(negedge clk); idle_all(); drive(0, 0, 0, 16'h10);
    @(posedge clk); #1;
    check("b4_load", 32'(rd_cnt(0)), 32'h10);
    @(negedge clk); drive(0, 1, 0, 16'h10); #1;
    check("b4_ce0", 32'(rd_b4(0)), 32'h0);
    @(posedge clk); #1;
    check("b4_hold", 32'(rd_cnt(0)), 32'h10);
    @(negedge clk); drive(0, 1, 1, 16'h10); #1;
    check("b4_ce1_low0", 32'(rd_b4(0)), 32'h1);
    @(posedge clk); #1;
    check("b4_10_to_0f", 32'(rd_cnt(0)), 32'h0F);
    @(negedge clk); drive(0, 1, 1, 16'h10); #1;
    check("b4_ce1_low_f", 32'(rd_b4(0)), 32'h0);
    @(posedge clk); #1;
    check("b4_0f_to_0e", 32'(rd_cnt(0)), 32'h0E);

    // Random run on all three instances against the reference model.
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int unsigned i = 0; i < 3; i++) begin
        r[i] = (cyc == 0) ? 1'b0 : ($urandom_range(15) != 0);
        c[i] = ($urandom_range(3) != 0);
        p[i] = ($urandom_range(3) == 0) ? (16'($urandom) & m_mask[i])
                                          : 16'($urandom_range(6));
        drive(i, r[i], c[i], p[i]);
      end
      #1;
      if (cyc != 0) begin
        for (int unsigned i = 0; i < 3; i++) begin
          check($sformatf("rnd%0d_i%0d_tc", cyc, i), 32'(rd_tc(i)),
                32'(c[i] && (m_cnt[i] == 0)));
          check($sformatf("rnd%0d_i%0d_b4", cyc, i), 32'(rd_b4(i)),
                32'(c[i] && (m_cnt[i][3:0] == 4'h0) && (m_ar[i] || m_cnt[i] != 0)));
        end
      end
      @(posedge clk); #1;
      for (int unsigned i = 0; i < 3; i++) begin
        model_step(i, r[i], c[i], p[i], uf);
        check($sformatf("rnd%0d_i%0d_counter", cyc, i), 32'(rd_cnt(i)), 32'(m_cnt[i]));
        check($sformatf("rnd%0d_i%0d_underflow", cyc, i), 32'(rd_uf(i)), 32'(uf));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
